// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared types and constants for the sequential BCD converter.
// Revision    : 1.0
// ============================================================================
package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd5;
  localparam logic [DIGIT_W-1:0] ADJ_ADD    = 4'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_adj
// Description : One BCD column correction: add 3 when the digit is 5 or more.
// Revision    : 1.0
// ============================================================================
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [DIGIT_W-1:0] o_digit
);

  always_comb begin
    o_digit = i_digit;
    if (i_digit >= ADJ_THRESH) o_digit = i_digit + ADJ_ADD;
  end

endmodule
`default_nettype wire

// File: rtl/seq_bin_to_bcd.sv
`default_nettype none
// ============================================================================
// Module      : seq_bin_to_bcd
// Description : Sequential double-dabble converter, one shift/adjust per clock.
// Revision    : 1.0
// ============================================================================
module seq_bin_to_bcd
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_start,
  input  logic [WIDTH-1:0]         i_bin,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [DIGIT_W*DIGITS-1:0] o_bcd
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  // Too few digits would silently truncate the largest inputs.
  if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_digits_check
    $error("seq_bin_to_bcd: DIGITS too small for WIDTH");
  end

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [BCD_W-1:0]   r_scratch, w_scratch_nxt;
  logic [WIDTH-1:0]   r_bin, w_bin_nxt;
  logic [BCD_W-1:0]   r_bcd, w_bcd_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W+WIDTH-1:0] w_shift;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_scratch[g*DIGIT_W +: DIGIT_W]),
      .o_digit (w_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Adjusted scratch and the remaining binary shift together as one register.
  assign w_shift = {w_adj, r_bin} << 1;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_scratch_nxt = r_scratch;
    w_bin_nxt     = r_bin;
    w_bcd_nxt     = r_bcd;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_bin_nxt     = i_bin;
          w_scratch_nxt = '0;
          w_cnt_nxt     = '0;
          w_busy_nxt    = 1'b1;
          w_state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        w_scratch_nxt = w_shift[BCD_W+WIDTH-1:WIDTH];
        w_bin_nxt     = w_shift[WIDTH-1:0];
        w_cnt_nxt     = r_cnt + CNT_W'(1);
        if (r_cnt == LAST_ITER) w_state_nxt = FINISH;
      end
      FINISH: begin
        w_bcd_nxt   = r_scratch;
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_scratch <= '0;
      r_bin     <= '0;
      r_bcd     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_scratch <= w_scratch_nxt;
      r_bin     <= w_bin_nxt;
      r_bcd     <= w_bcd_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_bcd  = r_bcd;

endmodule
`default_nettype wire
